// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch FSM encoding and default reset vector.
package ifu_fetch_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam int          INST_BYTES       = 4;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one outstanding word fetch at a time,
// single-entry instruction buffer toward the decoder, redirect support.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     fetch_cnt
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;
    logic            inst_valid_q, inst_valid_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic [31:0]     fetch_cnt_q, fetch_cnt_d;
    logic [XLEN-1:0] target;
    logic            req_fire;

    // Targets are forced to word alignment; low bits are dropped.
    assign target = redirect_pc & ~XLEN'(INST_BYTES - 1);

    // Request is gated by redirect so a stale address is never accepted.
    assign mem_req_valid = (state_q == ST_REQ) & ~redirect_valid & ~rst;
    assign mem_req_addr  = pc_q;
    assign req_fire      = mem_req_valid & mem_req_ready;

    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign fetch_cnt  = fetch_cnt_q;

    // Next-state logic for the fetch FSM, PC, buffer and counter.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_d       = drop_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        fetch_cnt_d  = fetch_cnt_q;
        if (inst_valid_q && inst_ready) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        unique case (state_q)
            ST_REQ: begin
                if (redirect_valid) begin
                    pc_d = target;
                end else if (req_fire) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid) begin
                    if (redirect_valid || drop_q) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                        if (redirect_valid) begin
                            pc_d = target;
                        end
                    end else begin
                        inst_d       = mem_resp_data;
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                        state_d      = ST_HOLD;
                    end
                end else if (redirect_valid) begin
                    pc_d   = target;
                    drop_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    inst_valid_d = 1'b0;
                    pc_d         = target;
                    state_d      = ST_REQ;
                end else if (inst_ready) begin
                    inst_valid_d = 1'b0;
                    pc_d         = pc_q + XLEN'(INST_BYTES);
                    state_d      = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= RESET_PC;
            fetch_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            fetch_cnt_q  <= fetch_cnt_d;
        end
    end

endmodule
